event_fifo: RTL

Parametrised synchronous event FIFO with a valid/ready handshake on both sides and first-word-fall-through output. It adds selectable overflow policies, programmable almost-full and almost-empty flags, a high-water mark and a saturating drop counter. It sits between the event capture logic and the event formatter/uplink, buffering bursty event records. It replaces the plain push/pop FIFO in new monitor paths.

---
 rtl/event_fifo_pkg.sv | 21 ++
 rtl/sat_counter.sv | 34 +++
 rtl/event_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/event_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo_pkg
// Description : Shared types and width helper for the event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package event_fifo_pkg;

    typedef enum logic [1:0] {
        OVF_BLOCK    = 2'd0,
        OVF_DROP_NEW = 2'd1,
        OVF_DROP_OLD = 2'd2
    } ovf_mode_e;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != C_MAX)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : FWFT valid/ready event FIFO with overflow policies, level
//               flags, high-water mark and saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo
    import event_fifo_pkg::*;
#(
    parameter int        W        = 72,
    parameter int        DEPTH    = 16,
    parameter ovf_mode_e OVF_MODE = OVF_BLOCK,
    parameter int        DROP_W   = 16,
    parameter int        CW       = count_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    input  logic [CW-1:0]     afull_thresh,
    input  logic [CW-1:0]     aempty_thresh,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     high_water,
    input  logic              hw_clear,
    output logic [DROP_W-1:0] drop_count,
    output logic              drop_pulse
);

    localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);
    localparam logic [PW-1:0]  C_LAST  = PW'(DEPTH - 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_high_water;
    logic          r_drop_pulse;

    logic          w_full;
    logic          w_not_empty;
    logic          w_pop;
    logic          w_in_ready;
    logic          w_overflow;
    logic          w_push;
    logic          w_advance_rd;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_hw_next;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == C_LAST) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        w_full      = (r_count == C_DEPTH);
        w_not_empty = (r_count != '0);
        w_pop       = w_not_empty && out_ready;
        w_in_ready  = (OVF_MODE == OVF_BLOCK) ? !w_full : 1'b1;
        // A full FIFO with no pop in the same cycle is the only loss case.
        w_overflow  = in_valid && w_full && !w_pop && (OVF_MODE != OVF_BLOCK);
        w_push      = in_valid && w_in_ready && !(w_overflow && (OVF_MODE == OVF_DROP_NEW));
        // Drop-old overwrites the head slot, so the read side moves with the write.
        w_advance_rd = w_pop || (w_overflow && (OVF_MODE == OVF_DROP_OLD));

        w_count_next = r_count;
        case ({w_push, w_advance_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase

        w_hw_next = r_high_water;
        if (hw_clear) begin
            w_hw_next = w_count_next;
        end else if (w_count_next > r_high_water) begin
            w_hw_next = w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_high_water <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_advance_rd) begin
                r_rptr <= next_ptr(r_rptr);
            end
            r_count      <= w_count_next;
            r_high_water <= w_hw_next;
            r_drop_pulse <= w_overflow;
        end
    end

    sat_counter #(
        .WIDTH (DROP_W)
    ) u_drop_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_overflow),
        .clr   (1'b0),
        .value (drop_count)
    );

    assign in_ready     = w_in_ready;
    assign out_valid    = w_not_empty;
    assign out_data     = w_not_empty ? r_mem[r_rptr] : '0;
    assign count        = r_count;
    assign high_water   = r_high_water;
    assign drop_pulse   = r_drop_pulse;
    assign almost_full  = (r_count >= afull_thresh);
    assign almost_empty = (r_count <= aempty_thresh);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !((OVF_MODE == OVF_BLOCK) && w_full && w_push));

    a_count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= C_DEPTH);

    a_no_drop_in_block: assert property (@(posedge clk) disable iff (!rst_n)
        !((OVF_MODE == OVF_BLOCK) && r_drop_pulse));

endmodule
`default_nettype wire
